// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg
//   Shared definitions for the xor_stream_scrambler slice:
//   - operand-select encodings for the 'mode' input
//   - default LFSR tap mask and reset seed
//   - output-slot occupancy enum (the only state beyond the LFSR)
//   - lfsr_step(): one Fibonacci shift of an LFSR state, computed at the
//     widest supported state width; callers truncate to their own width.
package xor_stream_pkg;

  localparam logic MODE_KEY  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam int MAX_LFSR_W = 32;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Occupancy of the single output register.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Feedback is the XOR of all tapped bits; the state shifts left and the
  // feedback bit enters at bit 0. Inputs narrower than MAX_LFSR_W must be
  // zero-extended so the unused upper taps contribute nothing.
  function automatic logic [MAX_LFSR_W-1:0] lfsr_step(
    input logic [MAX_LFSR_W-1:0] state,
    input logic [MAX_LFSR_W-1:0] taps
  );
    logic fb;
    fb = ^(state & taps);
    return {state[MAX_LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/xscr_lfsr.sv
// xscr_lfsr
//   Keystream generator for xor_stream_scrambler: a Fibonacci LFSR state
//   register with seed loading and a step enable.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, state -> RESET_SEED
//   seed_load  in   load 'seed' this cycle (wins over step_en)
//   seed       in   [LFSR_W] seed value; zero is replaced by 1
//   step_en    in   advance the LFSR by one shift
//   state      out  [LFSR_W] current LFSR state
module xscr_lfsr
  import xor_stream_pkg::*;
#(
  parameter int                 LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  TAPS       = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0]  RESET_SEED = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step_en,
  output logic [LFSR_W-1:0] state
);

  // An all-zero state would lock the LFSR forever, so a zero reset seed is
  // treated the same way as a zero loaded seed.
  localparam logic [LFSR_W-1:0] RESET_STATE =
    (RESET_SEED == '0) ? LFSR_W'(1) : RESET_SEED;

  logic [LFSR_W-1:0] stepped;
  logic [LFSR_W-1:0] seed_safe;

  always_comb begin
    stepped   = LFSR_W'(lfsr_step(MAX_LFSR_W'(state), MAX_LFSR_W'(TAPS)));
    seed_safe = (seed == '0) ? LFSR_W'(1) : seed;
  end

  // A seed load and a step in the same cycle: the load wins, so the new
  // seed is the first keystream value of the following beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else if (seed_load) begin
      state <= seed_safe;
    end else if (step_en) begin
      state <= stepped;
    end
  end

endmodule

// File: rtl/xor_stream_scrambler.sv
// xor_stream_scrambler
//   Registered streaming XOR unit with valid/ready on both sides. Each
//   accepted word is XORed with either a static key (mode 0) or the low
//   WIDTH bits of an internal LFSR keystream (mode 1). One-cycle latency,
//   single output register, full throughput under sustained flow.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   mode        in   0 = key XOR, 1 = LFSR keystream XOR (per accepted beat)
//   key         in   [WIDTH] static operand for mode 0
//   seed_load   in   load 'seed' into the LFSR this cycle
//   seed        in   [LFSR_W] LFSR seed (zero is replaced by 1)
//   in_valid    in   input word valid
//   in_ready    out  block can accept a word
//   in_data     in   [WIDTH] input word
//   out_valid   out  output word valid
//   out_ready   in   sink accepts the output word
//   out_data    out  [WIDTH] result word
//   out_parity  out  XOR-reduction of out_data (only with XSCR_PARITY_EN)
//
// Build option
//   XSCR_PARITY_EN  adds the registered out_parity output.
module xor_stream_scrambler
  import xor_stream_pkg::*;
#(
  parameter int                 WIDTH      = 8,
  parameter int                 LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  TAPS       = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0]  RESET_SEED = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [WIDTH-1:0]  key,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
`ifdef XSCR_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  slot_state_t       state_q;
  slot_state_t       state_d;
  logic              accept;
  logic              lfsr_step_en;
  logic [LFSR_W-1:0] lfsr_state;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  data_next;

  // The output register can take a new word when it is empty or when its
  // current word leaves this same cycle, so sustained flow has no bubble.
  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // The keystream advances only for words that actually consume it.
  assign lfsr_step_en = accept && (mode == MODE_LFSR);

  xscr_lfsr #(
    .LFSR_W     (LFSR_W),
    .TAPS       (TAPS),
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .step_en   (lfsr_step_en),
    .state     (lfsr_state)
  );

  // The operand uses the LFSR value before this beat's step or seed load.
  always_comb begin
    operand   = (mode == MODE_LFSR) ? WIDTH'(lfsr_state) : key;
    data_next = in_data ^ operand;
  end

  // Occupancy: fill on accept, drain when the word leaves with nothing
  // arriving to replace it, otherwise hold (including while stalled).
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // out_data only changes on accept, so it holds while stalled and keeps
  // its last value after the slot drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (accept) begin
      out_data <= data_next;
    end
  end

`ifdef XSCR_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^data_next;
    end
  end
`endif

endmodule

// File: tb/tb_xor_stream_scrambler.sv
// tb_xor_stream_scrambler
//   Self-checking bench for xor_stream_scrambler (default parameters).
//   A table of beats is streamed back-to-back, followed by hand-written
//   sequences for backpressure, seed loading and asynchronous reset.
//   Expected output words go into a queue when a beat is accepted and are
//   compared when the word is handed to the sink.
module tb_xor_stream_scrambler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  key = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b0;
  wire         in_ready;
  wire         out_valid;
  wire  [7:0]  out_data;
`ifdef XSCR_PARITY_EN
  wire         out_parity;
`endif

  int assertCount = 0;
  int failCount = 0;
  logic [7:0] expQ[$];

  typedef struct {
    string       name;
    logic        mode;
    logic [7:0]  key;
    logic [7:0]  din;
    logic [7:0]  expOut;
    logic [15:0] expLfsr;
  } vec_t;

  vec_t vecs[5];

  xor_stream_scrambler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .key       (key),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef XSCR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one beat starting at posedge+1, holds it until accepted (bounded)
  // and queues the expected result. Returns at posedge+1 after the accept.
  task automatic applyStimulus(input logic m, input logic [7:0] k,
                               input logic [7:0] d, input logic [7:0] expOut,
                               input string name);
    int waitCycles;
    bit done;
    waitCycles = 0;
    done = 1'b0;
    mode = m;
    key = k;
    in_data = d;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(expOut);
        done = 1'b1;
      end else if (waitCycles >= 20) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s_accept: in_ready stayed 0 for %0d cycles, expected 1",
                 name, waitCycles);
        done = 1'b1;
      end
      waitCycles++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: a word is consumed on the edge after a negedge that sees
  // out_valid && out_ready, so each word is compared exactly once.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL sb_unexpected: got word %0h, expected no word", out_data);
      end else begin
        logic [7:0] exp;
        exp = expQ.pop_front();
        checkOutput("sb_out_data", out_data, exp);
`ifdef XSCR_PARITY_EN
        checkOutput("sb_out_parity", out_parity, ^exp);
`endif
      end
    end
  end

  initial begin
    vecs[0] = '{"lfsr_beat0", 1'b1, 8'h00, 8'h00, 8'hE1, 16'h59C3};
    vecs[1] = '{"lfsr_beat1", 1'b1, 8'h00, 8'h00, 8'hC3, 16'hB387};
    vecs[2] = '{"key_beat",   1'b0, 8'h5A, 8'h3C, 8'h66, 16'hB387};
    vecs[3] = '{"lfsr_kept",  1'b1, 8'h00, 8'hFF, 8'h78, 16'h670F};
    vecs[4] = '{"key_odd",    1'b0, 8'h01, 8'h00, 8'h01, 16'h670F};

    // Reset state
    idle(2);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_lfsr", dut.lfsr_state, 16'hACE1);
`ifdef XSCR_PARITY_EN
    checkOutput("rst_out_parity", out_parity, 0);
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Back-to-back table beats
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].key, vecs[i].din, vecs[i].expOut,
                    vecs[i].name);
      checkOutput({vecs[i].name, "_lfsr"}, dut.lfsr_state, vecs[i].expLfsr);
    end
    idle(2);

    // Backpressure: one word held, a second waits for 5 cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h0F, "bp_first");
    mode = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_data", out_data, 8'h0F);
      checkOutput("bp_lfsr", dut.lfsr_state, 16'hCE1E);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready, 1);
    if (in_ready) expQ.push_back(8'h1E);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_release_lfsr", dut.lfsr_state, 16'h9C3C);
    idle(2);

    // Zero seed is replaced by 1
    seed_load = 1'b1;
    seed = 16'h0000;
    idle(1);
    seed_load = 1'b0;
    checkOutput("seed0_lfsr", dut.lfsr_state, 16'h0001);
    applyStimulus(1'b1, 8'h00, 8'hFF, 8'hFE, "seed0_beat");
    checkOutput("seed0_step", dut.lfsr_state, 16'h0002);
    idle(1);

    // Seed load together with an accept uses the old state
    seed_load = 1'b1;
    seed = 16'hACE1;
    idle(1);
    seed_load = 1'b0;
    checkOutput("reseed_lfsr", dut.lfsr_state, 16'hACE1);
    seed_load = 1'b1;
    seed = 16'h1234;
    applyStimulus(1'b1, 8'h00, 8'h00, 8'hE1, "same_cycle_beat");
    seed_load = 1'b0;
    checkOutput("same_cycle_lfsr", dut.lfsr_state, 16'h1234);
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h34, "after_load_beat");
    checkOutput("after_load_lfsr", dut.lfsr_state, 16'h2469);
    idle(2);

    // Asynchronous reset while a word is held
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'hAA, 8'h00, 8'hAA, "held_word");
    #2;
    checkOutput("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_in_ready", in_ready, 1);
    checkOutput("async_out_data", out_data, 0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("post_reset_lfsr", dut.lfsr_state, 16'hACE1);
    checkOutput("post_reset_out_valid", out_valid, 0);
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'h00, 8'hE1, "post_reset_beat");

    // Drain the scoreboard (bounded)
    for (int c = 0; c < 10 && expQ.size() != 0; c++) @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/xor_stream_scrambler.md
Name: xor_stream_scrambler

Overview:
- Parametrised, registered, streaming XOR unit.
- Each accepted input word is XORed with one of two operands:
  - a static key word (mode 0, a WIDTH-wide registered XOR), or
  - a keystream from an internal Fibonacci LFSR (mode 1, scrambler/descrambler).
- Sits between a data source and sink using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, data/key width in bits (1..LFSR_W).
- LFSR_W, 16, LFSR state width (WIDTH..32).
- TAPS, 16'hB400, feedback tap mask over LFSR state bits.
- RESET_SEED, 16'hACE1, LFSR value after reset; must be nonzero.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = static key XOR, 1 = LFSR keystream XOR; sampled per accepted beat.
- key  input  WIDTH  static operand for mode 0.
- seed_load  input  1  load seed into LFSR this cycle.
- seed  input  LFSR_W  value for seed_load.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- out_valid  output  1  output word valid.
- out_ready  input  1  sink accepts the output word.
- out_data  output  WIDTH  result word.
- out_parity  output  1  present only with XSCR_PARITY_EN; XOR-reduction of out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_parity=0, lfsr=RESET_SEED.
- Output stage is a 1-entry register.
  - in_ready = !out_valid || out_ready (combinational, no bubble on sustained flow).
  - accept = in_valid && in_ready.
- On accept, the next cycle has out_valid=1 and out_data = in_data ^ operand.
  - operand = key (mode 0) or lfsr[WIDTH-1:0] (mode 1), using the pre-step LFSR value.
  - Latency: 1 cycle.
- If out_valid && out_ready && !accept, out_valid goes to 0; out_data holds its last value.
- While out_valid && !out_ready: out_data and out_valid hold stable, and in_ready=0.
- LFSR step:
  - fb = ^(lfsr & TAPS); lfsr_next = {lfsr[LFSR_W-2:0], fb}.
  - Steps only on an accept with mode=1. It does not step in mode 0 or when idle.
- seed_load:
  - lfsr <= (seed==0) ? 1 : seed, preventing zero-state lock-up.
  - seed_load has priority over a simultaneous step.
  - A word accepted in the same cycle as seed_load uses the pre-load LFSR value. The loaded seed applies from the next beat.
- Mode switching mid-stream is legal. The LFSR state is preserved across mode 0 beats.
- Reset mid-transfer drops any held output word (out_valid=0). No replay.
- No FSM beyond the valid bit. States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on out_ready && !accept.
  - FULL->FULL on out_ready && accept, or on stall.

Optional Feature:
- Macro XSCR_PARITY_EN.
- Defined: out_parity port exists as a register, updated with ^(next out_data) in the same cycle out_data loads; reset value 0.
- Undefined: no out_parity port and no parity logic. All other behaviour is identical.

Decomposition:
- Package xor_stream_pkg holds:
  - localparam MODE_KEY=1'b0, MODE_LFSR=1'b1;
  - default TAPS and RESET_SEED constants;
  - function lfsr_step(state, taps) returning the next LFSR state.
- One sub-module, xscr_lfsr: owns the state register and handles seed_load, step enable and zero-seed substitution; outputs state.

Test Plan:
- Reset, mode=1, in_data=8'h00, two back-to-back accepts with out_ready=1 -> out_data=8'hE1 then 8'hC3; lfsr=16'h59C3 after the first beat.
- Mode=0, key=8'h5A, in_data=8'h3C -> out_data=8'h66 one cycle later; lfsr unchanged at 16'hACE1; with XSCR_PARITY_EN, out_parity=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; out_data stable for 5 cycles; no LFSR step; release -> next word accepted same cycle.
- seed_load with seed=16'h0000 -> lfsr=16'h0001; next mode 1 beat with in_data=8'hFF -> out_data=8'hFE.
- seed_load=1 and accept in the same cycle (lfsr=16'hACE1, seed=16'h1234, in_data=8'h00, mode=1) -> out_data=8'hE1; next beat uses keystream 8'h34.
- Assert rst_n=0 asynchronously while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge; lfsr=16'hACE1 after release.
